bexkat1_wb_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the pipelined Wishbone bus (stall/ack) used by the bexkat1 CPU.
- Sits directly downstream of the CPU's bus masters:
  - m0: data port (MAR-driven accesses).
  - m1: instruction-fetch port (PC-driven).
- Feeds the single system bus slave (memory/interconnect).
- Grants the bus per whole Wishbone cycle (cyc high span) and tracks outstanding pipelined requests so the slave is never over-subscribed.

---
 rtl/bexkat1_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bexkat1_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bexkat1_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bexkat1_wb_arbiter                                           |
// | Description : Two-master to one-slave pipelined Wishbone arbiter, granting |
// |               whole cyc spans and bounding outstanding requests.           |
// |               Define BEXKAT1_ARB_RR_EN for round-robin tie-breaking.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bexkat1_wb_arbiter #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int OWIDTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AWIDTH-1:0] m0_adr_i,
    input  logic [DWIDTH-1:0] m0_dat_i,
    input  logic [3:0]        m0_sel_i,
    output logic              m0_stall_o,
    output logic              m0_ack_o,
    output logic [DWIDTH-1:0] m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AWIDTH-1:0] m1_adr_i,
    input  logic [DWIDTH-1:0] m1_dat_i,
    input  logic [3:0]        m1_sel_i,
    output logic              m1_stall_o,
    output logic              m1_ack_o,
    output logic [DWIDTH-1:0] m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AWIDTH-1:0] s_adr_o,
    output logic [DWIDTH-1:0] s_dat_o,
    output logic [3:0]        s_sel_o,
    input  logic              s_stall_i,
    input  logic              s_ack_i,
    input  logic [DWIDTH-1:0] s_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [OWIDTH-1:0] c_count_one = OWIDTH'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [OWIDTH-1:0] r_count;
    logic              w_full;
    logic              w_pick_m1;
    logic              w_drop;
    logic              w_inc;
    logic              w_dec;

    assign w_full = (r_count == {OWIDTH{1'b1}});

`ifdef BEXKAT1_ARB_RR_EN
    // r_last_gnt: 0 = m0 was granted last, 1 = m1; a tie goes to the other one
    logic r_last_gnt;

    assign w_pick_m1 = m1_cyc_i & (~m0_cyc_i | ~r_last_gnt);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (r_state == IDLE && (m0_cyc_i || m1_cyc_i)) begin
            r_last_gnt <= w_pick_m1;
        end
    end
`else
    assign w_pick_m1 = m1_cyc_i & ~m0_cyc_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    w_state_next = w_pick_m1 ? GNT1 : GNT0;
                end
            end
            GNT0: if (!m0_cyc_i) w_state_next = IDLE;
            GNT1: if (!m1_cyc_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Slave side is a zero-latency pass-through of whichever master holds the grant
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        m0_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        case (r_state)
            GNT0: begin
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i & ~w_full;
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_sel_o    = m0_sel_i;
                m0_stall_o = s_stall_i | w_full;
                m0_ack_o   = s_ack_i;
            end
            GNT1: begin
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i & ~w_full;
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_sel_o    = m1_sel_i;
                m1_stall_o = s_stall_i | w_full;
                m1_ack_o   = s_ack_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign w_drop = ((r_state == GNT0) && !m0_cyc_i) || ((r_state == GNT1) && !m1_cyc_i);
    assign w_inc  = s_stb_o & ~s_stall_i;
    // A stray ack with nothing outstanding must not wrap the counter
    assign w_dec  = s_ack_i & (r_count != '0);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_drop || r_state == IDLE) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + c_count_one;
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - c_count_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bexkat1_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bexkat1_wb_arbiter                                        |
// | Description : Randomized bench for bexkat1_wb_arbiter against a grant /    |
// |               outstanding-count reference model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bexkat1_wb_arbiter;

    localparam int AWIDTH = 32;
    localparam int DWIDTH = 32;
    localparam int OWIDTH = 2;
    localparam int MAXO   = (1 << OWIDTH) - 1;
    localparam int NCYC   = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [AWIDTH-1:0] m0_adr_i = '0;
    logic [DWIDTH-1:0] m0_dat_i = '0;
    logic [3:0] m0_sel_i = '0;
    logic m0_stall_o, m0_ack_o;
    logic [DWIDTH-1:0] m0_dat_o;
    logic m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [AWIDTH-1:0] m1_adr_i = '0;
    logic [DWIDTH-1:0] m1_dat_i = '0;
    logic [3:0] m1_sel_i = '0;
    logic m1_stall_o, m1_ack_o;
    logic [DWIDTH-1:0] m1_dat_o;
    logic s_cyc_o, s_stb_o, s_we_o;
    logic [AWIDTH-1:0] s_adr_o;
    logic [DWIDTH-1:0] s_dat_o;
    logic [3:0] s_sel_o;
    logic s_stall_i = 0, s_ack_i = 0;
    logic [DWIDTH-1:0] s_dat_i = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bexkat1_wb_arbiter #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .OWIDTH(OWIDTH)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody), requests in flight, last grant
    int owner = -1;
    int cnt   = 0;
    int last  = 1;

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_cyc"}, 64'(s_cyc_o), 64'd0);
        check({tag, "_s_stb"}, 64'(s_stb_o), 64'd0);
        check({tag, "_s_bus"}, {s_we_o, s_sel_o, s_adr_o}, 64'd0);
        check({tag, "_s_dat"}, 64'(s_dat_o), 64'd0);
        check({tag, "_stall"}, {m0_stall_o, m1_stall_o}, 64'd3);
        check({tag, "_ack"},   {m0_ack_o, m1_ack_o}, 64'd0);
    endtask

    task automatic check_against_model();
        bit cyc[2], stb[2], we[2];
        logic [AWIDTH-1:0] adr[2];
        logic [DWIDTH-1:0] dat[2];
        logic [3:0] sel[2];
        bit full;
        bit e_stall[2], e_ack[2];
        cyc[0] = m0_cyc_i; stb[0] = m0_stb_i; we[0] = m0_we_i;
        adr[0] = m0_adr_i; dat[0] = m0_dat_i; sel[0] = m0_sel_i;
        cyc[1] = m1_cyc_i; stb[1] = m1_stb_i; we[1] = m1_we_i;
        adr[1] = m1_adr_i; dat[1] = m1_dat_i; sel[1] = m1_sel_i;
        full = (owner >= 0) && (cnt == MAXO);
        for (int k = 0; k < 2; k++) begin
            e_stall[k] = (owner == k) ? (s_stall_i || full) : 1'b1;
            e_ack[k]   = (owner == k) ? s_ack_i : 1'b0;
        end
        check("m0_stall", 64'(m0_stall_o), 64'(e_stall[0]));
        check("m1_stall", 64'(m1_stall_o), 64'(e_stall[1]));
        check("m0_ack",   64'(m0_ack_o),   64'(e_ack[0]));
        check("m1_ack",   64'(m1_ack_o),   64'(e_ack[1]));
        check("m0_dat",   64'(m0_dat_o),   64'(s_dat_i));
        check("m1_dat",   64'(m1_dat_o),   64'(s_dat_i));
        if (owner >= 0) begin
            bit e_stb, inc, dec;
            e_stb = stb[owner] && !full;
            check("s_cyc", 64'(s_cyc_o), 64'(cyc[owner]));
            check("s_stb", 64'(s_stb_o), 64'(e_stb));
            check("s_we",  64'(s_we_o),  64'(we[owner]));
            check("s_adr", 64'(s_adr_o), 64'(adr[owner]));
            check("s_dat", 64'(s_dat_o), 64'(dat[owner]));
            check("s_sel", 64'(s_sel_o), 64'(sel[owner]));
            if (!cyc[owner]) begin
                owner = -1;
                cnt   = 0;
            end else begin
                inc = e_stb && !s_stall_i;
                dec = s_ack_i && (cnt > 0);
                cnt = cnt + int'(inc) - int'(dec);
            end
        end else begin
            check_idle_outputs("idle");
            if (cyc[0] || cyc[1]) begin
`ifdef BEXKAT1_ARB_RR_EN
                if (cyc[0] && cyc[1]) owner = (last == 0) ? 1 : 0;
                else                  owner = cyc[0] ? 0 : 1;
                last = owner;
`else
                owner = cyc[0] ? 0 : 1;
`endif
                cnt = 0;
            end
        end
    endtask

    task automatic randomize_inputs();
        // cyc spans are long so the outstanding counter gets to fill up
        if (m0_cyc_i) m0_cyc_i = ($urandom_range(15) != 0);
        else          m0_cyc_i = ($urandom_range(3) == 0);
        if (m1_cyc_i) m1_cyc_i = ($urandom_range(15) != 0);
        else          m1_cyc_i = ($urandom_range(3) == 0);
        m0_stb_i  = m0_cyc_i && ($urandom_range(1) == 1);
        m1_stb_i  = m1_cyc_i && ($urandom_range(1) == 1);
        m0_we_i   = $urandom_range(1) == 1;
        m1_we_i   = $urandom_range(1) == 1;
        m0_adr_i  = $urandom;
        m1_adr_i  = $urandom;
        m0_dat_i  = $urandom;
        m1_dat_i  = $urandom;
        m0_sel_i  = 4'($urandom);
        m1_sel_i  = 4'($urandom);
        s_stall_i = ($urandom_range(3) == 0);
        s_ack_i   = ($urandom_range(4) < 2);
        s_dat_i   = $urandom;
    endtask

    initial begin
        m0_cyc_i = 1'b1;
        m0_stb_i = 1'b1;
        m0_adr_i = 32'h100;
        s_ack_i  = 1'b1;
        #2;
        check_idle_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #2;
        check_idle_outputs("rst_hold");
        rst_n = 1'b1;
        owner = -1; cnt = 0; last = 1;

        for (int i = 0; i < NCYC; i++) begin
            if (i > 0) randomize_inputs();
            #3;
            check_against_model();
            if (i == NCYC / 2) begin
                // asynchronous reset in the middle of whatever is in flight
                #1 rst_n = 1'b0;
                #1 check_idle_outputs("async_rst");
                owner = -1; cnt = 0; last = 1;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
